// File: rtl/dmem_read_arbiter.sv
// Round-robin arbiter for the shared 16-word dmem read port, with a
// two-stage tag pipeline that follows the one-cycle memory read latency.
module dmem_read_arbiter #(
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned ADDR_WIDTH = 15,
   parameter int unsigned LINE       = 16
) (
   input  logic                          i_CLK,
   input  logic                          i_RSTn,
   input  logic [N_REQ-1:0]              i_REQ,
   input  logic [N_REQ*ADDR_WIDTH-1:0]   i_ADDR,
   input  logic                          i_STALL,
   output logic [N_REQ-1:0]              o_GNT,
   output logic [ADDR_WIDTH-1:0]         o_DMEM_ADDR,
   output logic                          o_RVALID,
   output logic [2:0]                    o_RID,
   output logic                          o_RERR,
   output logic                          o_BUSY
);

   // Highest start address whose full line still fits in memory.
   localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'((1 << ADDR_WIDTH) - LINE);

   logic [2:0]            rr_ptr;
   logic [N_REQ-1:0]      req_rot;
   logic                  found;
   int unsigned           offset;
   int unsigned           pick;
   int unsigned           ptr_next;
   logic                  grant;
   logic [N_REQ-1:0]      gnt_vec;
   logic [ADDR_WIDTH-1:0] addr_sel;
   logic                  addr_err;

   logic                  s1_valid;
   logic                  s1_err;
   logic [2:0]            s1_id;
   logic                  s2_valid;
   logic                  s2_err;
   logic [2:0]            s2_id;

   // Rotate requests so the search always starts at bit 0, then map back.
   always_comb begin
      req_rot  = N_REQ'({i_REQ, i_REQ} >> rr_ptr);
      found    = 1'b0;
      offset   = 0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (!found && req_rot[i]) begin
            found  = 1'b1;
            offset = i;
         end
      end
      pick     = (32'(rr_ptr) + offset) % N_REQ;
      ptr_next = (pick + 1) % N_REQ;
      grant    = found & ~i_STALL;

      gnt_vec  = '0;
      addr_sel = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         if (k == pick) begin
            gnt_vec[k] = grant;
            addr_sel   = i_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
      addr_err = addr_sel > MAX_ADDR;
   end

   always_ff @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn) begin
         rr_ptr      <= '0;
         o_GNT       <= '0;
         o_DMEM_ADDR <= '0;
         s1_valid    <= 1'b0;
         s1_err      <= 1'b0;
         s1_id       <= '0;
         s2_valid    <= 1'b0;
         s2_err      <= 1'b0;
         s2_id       <= '0;
      end else begin
         o_GNT    <= gnt_vec;
         s1_valid <= grant;
         s1_err   <= grant & addr_err;
         s1_id    <= grant ? 3'(pick) : '0;
         s2_valid <= s1_valid;
         s2_err   <= s1_err;
         s2_id    <= s1_id;
         if (grant) begin
            rr_ptr <= 3'(ptr_next);
            // Rejected lines leave the memory address where it was.
            if (!addr_err) begin
               o_DMEM_ADDR <= addr_sel;
            end
         end
      end
   end

   assign o_RVALID = s2_valid & ~s2_err;
   assign o_RERR   = s2_valid & s2_err;
   assign o_RID    = s2_id;
   assign o_BUSY   = s1_valid | s2_valid;

endmodule

// File: tb/tb_dmem_read_arbiter.sv
// Bench for dmem_read_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a cycle-indexed behavioural model.
module tb_dmem_read_arbiter;

   localparam int N    = 4;
   localparam int AW   = 15;
   localparam int LINE = 16;
   localparam int MAXA = (1 << AW) - LINE;

   logic            clk   = 1'b0;
   logic            rst_n = 1'b1;
   logic [N-1:0]    req   = '0;
   logic [N*AW-1:0] addr  = '0;
   logic            stall = 1'b0;
   logic [N-1:0]    gnt;
   logic [AW-1:0]   dmem_addr;
   logic            rvalid;
   logic [2:0]      rid;
   logic            rerr;
   logic            busy;

   dmem_read_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .LINE(LINE)) u_dut (
      .i_CLK      (clk),
      .i_RSTn     (rst_n),
      .i_REQ      (req),
      .i_ADDR     (addr),
      .i_STALL    (stall),
      .o_GNT      (gnt),
      .o_DMEM_ADDR(dmem_addr),
      .o_RVALID   (rvalid),
      .o_RID      (rid),
      .o_RERR     (rerr),
      .o_BUSY     (busy)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;
   int m       = 0;   // model cycle number, advanced at each rising edge
   int ptr     = 0;
   int cur_addr  = 0;
   int next_addr = 0;
   int gnt_at[int];   // cycle -> requester whose grant is visible
   int due_id[int];   // cycle -> requester whose response is visible
   bit due_err[int];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, m);
      end
   endtask

   function automatic logic [N*AW-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
      logic [N*AW-1:0] v;
      v = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
      return v;
   endfunction

   task automatic compare();
      logic [N-1:0] eg;
      eg = '0;
      if (gnt_at.exists(m)) eg[gnt_at[m]] = 1'b1;
      chk("gnt", gnt, eg);
      chk("dmem_addr", dmem_addr, cur_addr);
      if (due_id.exists(m)) begin
         chk("rvalid", rvalid, !due_err[m]);
         chk("rerr", rerr, due_err[m]);
         chk("rid", rid, due_id[m]);
      end else begin
         chk("rvalid", rvalid, 0);
         chk("rerr", rerr, 0);
      end
      chk("busy", busy, due_id.exists(m) || due_id.exists(m + 1));
   endtask

   // Called at a falling edge: apply inputs, predict the next rising edge,
   // cross it, and compare at the following falling edge.
   task automatic step(input logic [N-1:0] r, input logic s, input logic [N*AW-1:0] a);
      int win;
      int ai;
      win = -1;
      req = r; stall = s; addr = a;
      next_addr = cur_addr;
      if (!s) begin
         for (int j = 0; j < N; j++) begin
            int k;
            k = (ptr + j) % N;
            if (win < 0 && r[k]) win = k;
         end
      end
      if (win >= 0) begin
         ai = int'(a[win*AW +: AW]);
         gnt_at[m + 1]  = win;
         due_id[m + 2]  = win;
         due_err[m + 2] = ai > MAXA;
         if (ai <= MAXA) next_addr = ai;
         ptr = (win + 1) % N;
      end
      @(posedge clk);
      m++;
      cur_addr = next_addr;
      @(negedge clk);
      compare();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      #1;
      chk("rst_gnt", gnt, 0);
      chk("rst_dmem_addr", dmem_addr, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rerr", rerr, 0);
      chk("rst_rid", rid, 0);
      chk("rst_busy", busy, 0);
      ptr = 0;
      cur_addr = 0;
      gnt_at.delete();
      due_id.delete();
      due_err.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [N*AW-1:0] a;
      @(negedge clk);
      do_reset();

      // Single request, no contention.
      a = pack4(16'h0100, 0, 0, 0);
      step(4'b0001, 1'b0, a);
      chk("lit_single_gnt", gnt, 4'b0001);
      chk("lit_single_addr", dmem_addr, 16'h0100);
      step(4'b0000, 1'b0, a);
      chk("lit_single_rvalid", rvalid, 1);
      chk("lit_single_rid", rid, 0);

      // Full contention from pointer 0.
      do_reset();
      a = pack4(16, 32, 48, 64);
      for (int i = 0; i < 6; i++) begin
         logic [N-1:0] e;
         e = '0;
         e[i % N] = 1'b1;
         step(4'b1111, 1'b0, a);
         chk("lit_rr_gnt", gnt, e);
         if (i >= 1) begin
            chk("lit_rr_rvalid", rvalid, 1);
            chk("lit_rr_rid", rid, (i - 1) % N);
         end
      end

      // Boundary addresses on requester 1 (pointer is 2 here).
      a = pack4(0, MAXA, 0, 0);
      step(4'b0010, 1'b0, a);
      chk("lit_bnd_gnt", gnt, 4'b0010);
      chk("lit_bnd_addr", dmem_addr, MAXA);
      a = pack4(0, MAXA + 1, 0, 0);
      step(4'b0010, 1'b0, a);
      chk("lit_bnd_err_gnt", gnt, 4'b0010);
      chk("lit_bnd_addr_hold", dmem_addr, MAXA);
      chk("lit_bnd_ok_rvalid", rvalid, 1);
      step(4'b0000, 1'b0, a);
      chk("lit_bnd_rerr", rerr, 1);
      chk("lit_bnd_rvalid", rvalid, 0);
      chk("lit_bnd_rid", rid, 1);

      // Stall holds the pointer.
      a = pack4(100, 200, 300, 400);
      step(4'b0001, 1'b0, a);
      chk("lit_pre_stall_gnt", gnt, 4'b0001);
      for (int i = 0; i < 3; i++) begin
         step(4'b0110, 1'b1, a);
         chk("lit_stall_gnt", gnt, 0);
      end
      step(4'b0110, 1'b0, a);
      chk("lit_post_stall_gnt", gnt, 4'b0010);

      // Reset while a grant is in flight.
      step(4'b0100, 1'b0, a);
      chk("lit_flight_gnt", gnt, 4'b0100);
      do_reset();
      step(4'b0000, 1'b0, a);
      chk("lit_flight_rvalid", rvalid, 0);
      step(4'b1111, 1'b0, a);
      chk("lit_after_rst_gnt", gnt, 4'b0001);

      // Sole requester back-to-back.
      for (int i = 0; i < 6; i++) begin
         step((i < 4) ? 4'b0100 : 4'b0000, 1'b0, a);
         if (i < 4) chk("lit_sole_gnt", gnt, 4'b0100);
         if (i >= 1 && i <= 4) begin
            chk("lit_sole_rvalid", rvalid, 1);
            chk("lit_sole_rid", rid, 2);
         end
      end

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         logic [N*AW-1:0] ra;
         ra = '0;
         for (int k = 0; k < N; k++) begin
            int v;
            case ($urandom_range(0, 7))
               0:       v = MAXA;
               1:       v = MAXA + 1;
               2:       v = (1 << AW) - 1;
               default: v = int'($urandom_range(0, (1 << AW) - 1));
            endcase
            ra[k*AW +: AW] = AW'(v);
         end
         if ($urandom_range(0, 149) == 0) do_reset();
         step(N'($urandom_range(0, (1 << N) - 1)), $urandom_range(0, 7) == 0, ra);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/dmem_read_arbiter.md
# dmem_read_arbiter

Round-robin arbiter that shares the single wide read port of `dmem` (16 consecutive 32-bit words per access) between `N_REQ` requesters. It sits directly in front of `dmem`: it drives the memory address, tracks the one-cycle memory read latency in a tag pipeline, and tells each requester when the 16-word line on `dmem`'s outputs belongs to it. It also rejects line addresses that would run past the end of memory.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `ADDR_WIDTH`, 15, `dmem` word-address width
- `LINE`, 16, words returned per `dmem` access
- `i_CLK` input 1: clock, shared with `dmem` `i_CLKa`/`i_CLKb`
- `i_RSTn` input 1: asynchronous active-low reset
- `i_REQ` input N_REQ: per-requester request, level, held until granted
- `i_ADDR` input N_REQ*ADDR_WIDTH: requester k start address at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- `i_STALL` input 1: when high, no new grant is issued; in-flight reads still complete
- `o_GNT` output N_REQ: one-hot grant, registered, high one cycle
- `o_DMEM_ADDR` output ADDR_WIDTH: registered address to `dmem` `i_ADDR`
- `o_RVALID` output 1: `dmem` `o_RDATAa..p` hold a valid line this cycle
- `o_RID` output 3: requester index owning the current `o_RVALID`/`o_RERR`
- `o_RERR` output 1: the returned access was rejected (address out of range); data is invalid
- `o_BUSY` output 1: an access is in the tag pipeline

## Operation
- Arbitration happens at every rising edge where `i_STALL`=0 and `i_REQ`≠0.
  - The search starts at pointer `rr_ptr` and picks the first k with `i_REQ[k]`=1, scanning k = rr_ptr, rr_ptr+1, … modulo N_REQ.
  - After a grant to k, `rr_ptr` becomes (k+1) mod N_REQ.
  - `rr_ptr` is unchanged when nothing is granted.
- Each grant does the following at that edge:
  - `o_GNT[k]` is set.
  - `o_DMEM_ADDR` is set to `i_ADDR[k]`.
  - Stage-1 tag {valid=1, id=k, err=e} is loaded.
- e = 1 when `i_ADDR[k]` > 2^ADDR_WIDTH − LINE (32752 by default).
  - `o_DMEM_ADDR` then holds its previous value.
  - The access still flows through the pipeline as an error response.
- Stage 2 takes stage 1 at the next edge. `o_RVALID` = stage2.valid & ~stage2.err, `o_RERR` = stage2.valid & stage2.err, and `o_RID` = stage2.id.
- With no grant, stage 1 is loaded with valid=0, and `o_DMEM_ADDR` holds its value.
- A requester must drop `i_REQ` in the cycle `o_GNT` is high. If `i_REQ` is still high at the next edge, it is treated as a new request.
- `o_BUSY` = stage1.valid | stage2.valid.
- Throughput is one access per cycle. Back-to-back grants are allowed, including to the same requester when it is the only one requesting.

## Timing
- Edge E0: request sampled and grant decided. In cycle E0→E1, `o_GNT` is high and `o_DMEM_ADDR` is valid.
- Edge E1: `dmem` registers the line. In cycle E1→E2, `o_RVALID` (or `o_RERR`) is high with `o_RID`, and `dmem` `o_RDATAa..p` are valid.
- Latency from the sampling edge to data valid is 2 cycles. The response is high for exactly one cycle per grant.
- Reset (`i_RSTn`=0, asynchronous) forces the following immediately:
  - `o_GNT`=0, `o_DMEM_ADDR`=0, `rr_ptr`=0
  - both tag stages invalid, so `o_RVALID`=`o_RERR`=0, `o_RID`=0, `o_BUSY`=0
- In-flight accesses are discarded on reset. No response is produced for them after release.
- The first arbitration is at the first rising edge with `i_RSTn`=1.
- `i_STALL` rising while a grant is in flight has no effect on that grant's response. `i_STALL` sampled high at an edge produces no grant at that edge.
- If a requester drops `i_REQ` before being granted, it is simply not granted. There is no error.
- Address 32752 is legal and reads words 32752..32767. Address 32753 is `o_RERR`.

## Test plan
- Single request, no contention: `i_REQ`=0001, addr0=0x0100, with `dmem.dat` holding word n = n.
  - At E0+1: `o_GNT`=0001 and `o_DMEM_ADDR`=0x0100.
  - At E0+2: `o_RVALID`=1, `o_RID`=0, `o_RDATAa`=0x100, `o_RDATAp`=0x10F.
- All four requesting continuously, re-raising after each grant: grants are 0001, 0010, 0100, 1000, 0001, one per cycle. `o_RID` follows 0,1,2,3,0 two cycles later with `o_RVALID` high continuously.
- Boundary addresses:
  - addr1=32752 gives `o_RVALID`=1, `o_RDATAp`=word 32767.
  - addr1=32753 gives `o_GNT`=0010 and, 2 cycles later, `o_RERR`=1, `o_RVALID`=0, `o_RID`=1; `o_DMEM_ADDR` is unchanged.
- Stall: hold `i_STALL`=1 for 3 cycles with `i_REQ`=0110. There are no grants and `rr_ptr` does not move. After release, the first grant goes to the lowest index ≥ `rr_ptr`.
- Reset mid-flight: grant at E0, then assert `i_RSTn`=0 between E0 and E1.
  - `o_GNT`, `o_BUSY` and `o_RVALID` drop immediately and stay 0 until a new grant after release.
  - The next grant starts the search from requester 0.
- Sole requester back-to-back: `i_REQ[2]` held high for 4 edges gives 4 consecutive `o_GNT`=0100 pulses and 4 consecutive `o_RVALID` pulses with `o_RID`=2.
